// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer: write measure command, wait conversion, read 6 bytes, CRC-check.
// Latency: one command per byte-engine response; done 2 cycles after the final STOP response.
// Backpressure: cmd_valid holds a stable command until cmd_ready; one command outstanding at a time.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start / busy / done         measurement request, in-progress flag, 1-cycle completion pulse
//   err_code                    0 ok, 1 address NACK, 2 command NACK, 3 CRC failure (held until next done)
//   t_raw / rh_raw              raw temperature / humidity words (loaded only on a CRC-clean run)
//   cmd_valid/ready/op/wdata/nack  command channel to the I2C byte engine
//   rsp_valid/rdata/nack        response channel from the I2C byte engine
module sht40_meas_ctrl #(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter int unsigned WAIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [15:0] t_raw,
  output logic [15:0] rh_raw,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        rsp_nack
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  // Counter starts at 0 on the cycle after the W_STOP response, so the last
  // count value is WAIT_CYCLES-1 and START becomes visible WAIT_CYCLES+1 after it.
  localparam logic [CW-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_W_START, S_W_ADDR, S_W_CMD, S_W_STOP, S_WAIT,
    S_R_START, S_R_ADDR, S_R_DATA, S_R_STOP, S_CHECK, S_ERR_STOP, S_DONE
  } state_t;

  state_t          state;
  logic            pending;
  logic [CW-1:0]   wait_cnt;
  logic [2:0]      rd_idx;
  logic [47:0]     shreg;
  logic [1:0]      code_q;

  // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic rsp_ok;
  logic crc_ok;

  // A response counts only against a command that has been accepted; stray
  // pulses (idle, waiting, or after a reset) fall through.
  assign rsp_ok = rsp_valid && (pending || (cmd_valid && cmd_ready));
  assign crc_ok = (crc8(shreg[47:32]) == shreg[31:24]) &&
                  (crc8(shreg[23:8])  == shreg[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      wait_cnt  <= '0;
      rd_idx    <= 3'd0;
      shreg     <= 48'd0;
      code_q    <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= 2'd0;
      t_raw     <= 16'd0;
      rh_raw    <= 16'd0;
      cmd_valid <= 1'b0;
      cmd_op    <= 2'd0;
      cmd_wdata <= 8'd0;
      cmd_nack  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
        pending   <= 1'b1;
      end
      if (rsp_ok) pending <= 1'b0;

      // Each transition that needs a new command raises cmd_valid in the same
      // cycle it advances, so the request is visible right after the response.
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            state     <= S_W_START;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_wdata, cmd_nack} <= {OP_START, 8'h00, 1'b0};
          end
        end
        S_W_START: begin
          if (rsp_ok) begin
            state     <= S_W_ADDR;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_wdata, cmd_nack} <= {OP_WRITE, DEV_ADDR, 1'b0, 1'b0};
          end
        end
        S_W_ADDR: begin
          if (rsp_ok) begin
            cmd_valid <= 1'b1;
            if (rsp_nack) begin
              state  <= S_ERR_STOP;
              code_q <= 2'd1;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_STOP, 8'h00, 1'b0};
            end else begin
              state <= S_W_CMD;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_WRITE, MEAS_CMD, 1'b0};
            end
          end
        end
        S_W_CMD: begin
          if (rsp_ok) begin
            cmd_valid <= 1'b1;
            {cmd_op, cmd_wdata, cmd_nack} <= {OP_STOP, 8'h00, 1'b0};
            if (rsp_nack) begin
              state  <= S_ERR_STOP;
              code_q <= 2'd2;
            end else begin
              state <= S_W_STOP;
            end
          end
        end
        S_W_STOP: begin
          if (rsp_ok) begin
            wait_cnt <= '0;
            if (WAIT_CYCLES == 0) begin
              state     <= S_R_START;
              cmd_valid <= 1'b1;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_START, 8'h00, 1'b0};
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= S_R_START;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_wdata, cmd_nack} <= {OP_START, 8'h00, 1'b0};
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_R_START: begin
          if (rsp_ok) begin
            state     <= S_R_ADDR;
            cmd_valid <= 1'b1;
            {cmd_op, cmd_wdata, cmd_nack} <= {OP_WRITE, DEV_ADDR, 1'b1, 1'b0};
          end
        end
        S_R_ADDR: begin
          if (rsp_ok) begin
            cmd_valid <= 1'b1;
            if (rsp_nack) begin
              state  <= S_ERR_STOP;
              code_q <= 2'd1;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_STOP, 8'h00, 1'b0};
            end else begin
              state  <= S_R_DATA;
              rd_idx <= 3'd0;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_READ, 8'h00, 1'b0};
            end
          end
        end
        S_R_DATA: begin
          if (rsp_ok) begin
            shreg     <= {shreg[39:0], rsp_rdata};
            cmd_valid <= 1'b1;
            if (rd_idx == 3'd5) begin
              state <= S_R_STOP;
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_STOP, 8'h00, 1'b0};
            end else begin
              rd_idx <= rd_idx + 1'b1;
              // Master NACKs only the sixth (last) byte.
              {cmd_op, cmd_wdata, cmd_nack} <= {OP_READ, 8'h00, rd_idx == 3'd4};
            end
          end
        end
        S_R_STOP: begin
          if (rsp_ok) state <= S_CHECK;
        end
        S_CHECK: begin
          done  <= 1'b1;
          state <= S_DONE;
          if (crc_ok) begin
            err_code <= 2'd0;
            t_raw    <= shreg[47:32];
            rh_raw   <= shreg[23:8];
          end else begin
            err_code <= 2'd3;
          end
        end
        S_ERR_STOP: begin
          if (rsp_ok) begin
            done     <= 1'b1;
            err_code <= code_q;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sht40_meas_ctrl.sv
module tb_sht40_meas_ctrl;

  localparam int WAITC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  err_code;
  logic [15:0] t_raw, rh_raw;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        cmd_nack;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_rdata = 8'h00;
  logic        rsp_nack = 1'b0;

  sht40_meas_ctrl #(.DEV_ADDR(7'h44), .MEAS_CMD(8'hFD), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_code(err_code), .t_raw(t_raw), .rh_raw(rh_raw),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] wd;
    logic       nk;
  } cmd_t;

  int n_vec = 0;
  int n_bad = 0;

  // scenario and reference model state
  logic [47:0] s_bytes;
  bit          s_nwa, s_nc, s_nra, s_stall;
  cmd_t        exp_q[$];
  int          exp_idx;
  logic [1:0]  p_code;
  bit          p_errpath;
  bit          m_busy;
  logic [15:0] m_t, m_rh;
  logic [1:0]  m_err;
  int          exp_done_cyc, exp_rise;
  // byte-engine model state
  bit          outst;
  int          rsp_at;
  cmd_t        cur;
  int          rd_i;
  int          stall;
  bit          prev_valid, prev_xfer, force_stray;
  cmd_t        prev_cmd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] op, input logic [7:0] wd, input logic nk);
    cmd_t c;
    c.op = op; c.wd = wd; c.nk = nk;
    return c;
  endfunction

  function automatic logic [7:0] crc8m(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] msg [2];
    msg[0] = a; msg[1] = b; c = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      c = c ^ msg[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [47:0] good(input logic [15:0] t, input logic [15:0] rh);
    return {t, crc8m(t[15:8], t[7:0]), rh, crc8m(rh[15:8], rh[7:0])};
  endfunction

  function automatic logic [7:0] sbyte(input int i);
    return s_bytes[47 - 8*i -: 8];
  endfunction

  // Expected command list and outcome of one measurement, from the protocol rules.
  function automatic void build_expect();
    exp_q.delete();
    exp_idx = 0; rd_i = 0; p_errpath = 1'b1;
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h88, 1'b0));
    if (s_nwa) begin exp_q.push_back(mk(2'd3, 8'h00, 1'b0)); p_code = 2'd1; return; end
    exp_q.push_back(mk(2'd1, 8'hFD, 1'b0));
    if (s_nc) begin exp_q.push_back(mk(2'd3, 8'h00, 1'b0)); p_code = 2'd2; return; end
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd0, 8'h00, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h89, 1'b0));
    if (s_nra) begin exp_q.push_back(mk(2'd3, 8'h00, 1'b0)); p_code = 2'd1; return; end
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(2'd2, 8'h00, i == 5));
    exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
    p_errpath = 1'b0;
    p_code = (crc8m(sbyte(0), sbyte(1)) == sbyte(2) && crc8m(sbyte(3), sbyte(4)) == sbyte(5)) ? 2'd0 : 2'd3;
  endfunction

  function automatic void reset_model();
    m_busy = 1'b0; m_t = 16'd0; m_rh = 16'd0; m_err = 2'd0;
    exp_done_cyc = -1; exp_rise = -1; outst = 1'b0; stall = 0;
    prev_valid = 1'b0; prev_xfer = 1'b0; prev_cmd = '0; exp_q.delete(); exp_idx = 0;
  endfunction

  // One cycle: check outputs against the model, then drive this cycle's inputs.
  task automatic step(input bit st);
    bit   dn, acc, xfer;
    cmd_t now_c;
    now_c = mk(cmd_op, cmd_wdata, cmd_nack);
    dn = (exp_done_cyc == cyc);
    if (dn) begin
      m_err = p_code;
      if (p_code == 2'd0) begin m_t = s_bytes[47:32]; m_rh = s_bytes[23:8]; end
      exp_done_cyc = -1;
    end
    chk("busy", busy, m_busy);
    chk("done", done, dn);
    chk("err_code", err_code, m_err);
    chk("t_raw", t_raw, m_t);
    chk("rh_raw", rh_raw, m_rh);
    if (!m_busy) chk("idle_cmd_valid", cmd_valid, 0);
    if (prev_xfer) chk("valid_drop", cmd_valid, 0);
    else if (prev_valid && cmd_valid) chk("cmd_stable", now_c, prev_cmd);
    if (cmd_valid && !prev_valid) begin
      chk("overlap_rise", outst, 0);
      if (exp_rise >= 0) begin chk("rise_cycle", cyc, exp_rise); exp_rise = -1; end
      if (s_stall && now_c.op == 2'd1 && now_c.wd == 8'hFD) stall = 50;
    end

    acc = st && !m_busy;
    if (dn) m_busy = 1'b0;
    if (acc) begin m_busy = 1'b1; build_expect(); exp_rise = cyc + 1; end

    if (stall > 0) begin cmd_ready = 1'b0; stall--; end
    else cmd_ready = ($urandom_range(0, 3) != 0);
    xfer = cmd_valid && cmd_ready;

    rsp_valid = 1'b0; rsp_rdata = 8'($urandom); rsp_nack = 1'($urandom);
    if (outst && cyc == rsp_at) begin
      rsp_valid = 1'b1; outst = 1'b0;
      if (cur.op == 2'd1)
        rsp_nack = (cur.wd == 8'h88 && s_nwa) || (cur.wd == 8'hFD && s_nc) || (cur.wd == 8'h89 && s_nra);
      if (cur.op == 2'd2) begin rsp_rdata = sbyte(rd_i); rd_i++; end
      if (cur.op == 2'd3 && exp_idx < exp_q.size()) exp_rise = cyc + 1 + WAITC;
      if (cur.op == 2'd2 && cur.nk) exp_rise = cyc + 1;
      if (exp_idx == exp_q.size() && exp_q.size() > 0) exp_done_cyc = cyc + (p_errpath ? 1 : 2);
    end else if (!outst && !cmd_valid && (force_stray || $urandom_range(0, 15) == 0)) begin
      rsp_valid = 1'b1; force_stray = 1'b0;
    end

    if (xfer) begin
      if (exp_idx < exp_q.size()) begin
        chk("cmd_op", now_c.op, exp_q[exp_idx].op);
        if (exp_q[exp_idx].op == 2'd1) chk("cmd_wdata", now_c.wd, exp_q[exp_idx].wd);
        if (exp_q[exp_idx].op == 2'd2) chk("cmd_nack", now_c.nk, exp_q[exp_idx].nk);
      end else begin
        chk("extra_cmd", exp_idx, exp_q.size());
      end
      exp_idx++; cur = now_c; outst = 1'b1; rsp_at = cyc + $urandom_range(1, 4);
    end

    prev_valid = cmd_valid; prev_cmd = now_c; prev_xfer = xfer;
    start = st;
  endtask

  task automatic tick(input bit st);
    @(negedge clk);
    step(st);
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    reset_model();
    tick(0); tick(0);
    #2 rst_n = 1'b1;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_t", t_raw, 0);
    chk("rst_rh", rh_raw, 0);
    chk("rst_cmd_fields", {cmd_op, cmd_wdata, cmd_nack}, 0);
    reset_model();
    repeat (3) tick(0);
    #2 rst_n = 1'b1;
    force_stray = 1'b1;
    repeat (4) tick(0);
  endtask

  task automatic run(input logic [47:0] b, input bit nwa, input bit nc, input bit nra,
                     input bit stl, input bit poke, input bit rst_mid);
    int budget;
    bit st, poked_w, poked_r;
    s_bytes = b; s_nwa = nwa; s_nc = nc; s_nra = nra; s_stall = stl;
    poked_w = 1'b0; poked_r = 1'b0; budget = 0;
    tick(1);
    while (m_busy && budget < 3000) begin
      st = 1'b0;
      if (poke && !poked_w && exp_idx == 4 && exp_rise > cyc + 3) begin st = 1'b1; poked_w = 1'b1; end
      if (poke && !poked_r && outst && cur.op == 2'd2) begin st = 1'b1; poked_r = 1'b1; end
      tick(st);
      if (rst_mid && rd_i == 3) begin mid_reset(); return; end
      budget++;
    end
    if (m_busy) begin
      chk("run_timeout", m_busy, 0);
      hard_reset();
    end
    repeat (4) tick(0);
  endtask

  initial begin
    logic [47:0] rb;
    int r;
    reset_model();
    s_bytes = '0; s_nwa = 0; s_nc = 0; s_nra = 0; s_stall = 0; force_stray = 0; p_code = 0; p_errpath = 0;
    chk("crc_model_beef", crc8m(8'hBE, 8'hEF), 8'h92);
    chk("crc_model_0000", crc8m(8'h00, 8'h00), 8'h81);
    repeat (3) tick(0);
    #2 rst_n = 1'b1;
    repeat (2) tick(0);

    run(48'hBEEF92000081, 0, 0, 0, 0, 0, 0);
    chk("nominal_t", t_raw, 16'hBEEF);
    chk("nominal_rh", rh_raw, 16'h0000);
    chk("nominal_err", err_code, 0);

    run(48'hBEEF92000081, 1, 0, 0, 0, 0, 0);
    chk("waddr_nack_err", err_code, 1);
    chk("waddr_nack_t", t_raw, 16'hBEEF);

    run(good(16'h6A3C, 16'h1234), 0, 0, 0, 0, 0, 0);
    chk("prior_ok_t", t_raw, 16'h6A3C);
    run(48'hBEEF93000081, 0, 0, 0, 0, 0, 0);
    chk("crc_fail_err", err_code, 3);
    chk("crc_fail_t_kept", t_raw, 16'h6A3C);
    chk("crc_fail_rh_kept", rh_raw, 16'h1234);

    run(good(16'h1111, 16'h2222), 0, 1, 0, 0, 0, 0);
    chk("cmd_nack_err", err_code, 2);
    run(good(16'h3333, 16'h4444), 0, 0, 1, 0, 0, 0);
    chk("raddr_nack_err", err_code, 1);

    run(good(16'h5A5A, 16'hA5A5), 0, 0, 0, 1, 1, 0);
    chk("stall_poke_t", t_raw, 16'h5A5A);

    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 9);
      rb = good(16'($urandom), 16'($urandom));
      if (r == 3) rb[$urandom_range(0, 7) + ($urandom_range(0, 1) ? 24 : 0)] ^= 1'b1;
      run(rb, r == 0, r == 1, r == 2, 0, $urandom_range(0, 1), 0);
    end

    run(good(16'h7777, 16'h8888), 0, 0, 0, 0, 0, 1);
    run(48'hBEEF92000081, 0, 0, 0, 0, 0, 0);
    chk("post_reset_err", err_code, 0);
    chk("post_reset_t", t_raw, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
